// File: rtl/ble_auth_tx.sv
// UART 8N1 command transmitter standing in for the BLE module: sends 'g'/'s' frames
// to the Segway RX pin, with a one-deep pending slot so a mid-frame request is kept.
module ble_auth_tx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_cmd,
    input  logic stop_cmd,
    output logic TX,
    output logic tx_busy,
    output logic tx_done
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned FRM_W = 10;
    localparam int unsigned BIT_W = 4;

    localparam logic [7:0]       CHAR_G    = 8'h67;
    localparam logic [7:0]       CHAR_S    = 8'h73;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(BAUD_DIV - 2);
    localparam logic [BIT_W-1:0] BIT_STOP  = BIT_W'(9);

    typedef enum logic {
        IDLE,
        XMIT
    } state_t;

    state_t             state_q,     state_nxt;
    logic [FRM_W-1:0]   shift_q,     shift_nxt;
    logic [CNT_W-1:0]   baud_q,      baud_nxt;
    logic [BIT_W-1:0]   bit_q,       bit_nxt;
    logic               pend_vld_q,  pend_vld_nxt;
    logic [7:0]         pend_byte_q, pend_byte_nxt;
    logic               busy_q,      busy_nxt;
    logic               done_q,      done_nxt;

    logic               req_vld;
    logic [7:0]         req_byte;
    logic               mrg_vld;
    logic [7:0]         mrg_byte;

    // State and datapath registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '1;
            baud_q      <= '0;
            bit_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_byte_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            shift_q     <= shift_nxt;
            baud_q      <= baud_nxt;
            bit_q       <= bit_nxt;
            pend_vld_q  <= pend_vld_nxt;
            pend_byte_q <= pend_byte_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    // Next-state, shifter, counters and pending-slot update.
    always_comb begin
        state_nxt     = state_q;
        shift_nxt     = shift_q;
        baud_nxt      = baud_q;
        bit_nxt       = bit_q;
        pend_vld_nxt  = pend_vld_q;
        pend_byte_nxt = pend_byte_q;

        req_vld  = go_cmd | stop_cmd;
        req_byte = stop_cmd ? CHAR_S : CHAR_G;

        // Latest request wins, except a waiting 's' is never replaced by a lone 'g'.
        mrg_vld  = pend_vld_q;
        mrg_byte = pend_byte_q;
        if (req_vld && !(pend_vld_q && (pend_byte_q == CHAR_S) && !stop_cmd)) begin
            mrg_vld  = 1'b1;
            mrg_byte = req_byte;
        end

        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    state_nxt = XMIT;
                    shift_nxt = {1'b1, req_byte, 1'b0};
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            XMIT: begin
                pend_vld_nxt  = mrg_vld;
                pend_byte_nxt = mrg_byte;
                if (baud_q == BAUD_LAST) begin
                    baud_nxt = '0;
                    if (bit_q == BIT_STOP) begin
                        bit_nxt      = '0;
                        pend_vld_nxt = 1'b0;
                        if (mrg_vld) begin
                            shift_nxt = {1'b1, mrg_byte, 1'b0};
                        end else begin
                            state_nxt = IDLE;
                            shift_nxt = '1;
                        end
                    end else begin
                        shift_nxt = {1'b1, shift_q[FRM_W-1:1]};
                        bit_nxt   = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_nxt = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                shift_nxt = '1;
            end
        endcase

        busy_nxt = (state_nxt == XMIT);
        // Registered pulse lands on the last cycle of the stop bit.
        done_nxt = (state_q == XMIT) && (bit_q == BIT_STOP) && (baud_q == BAUD_PRE);
    end

    assign TX      = shift_q[0];
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_ble_auth_tx.sv
// Scoreboard bench for ble_auth_tx: directed requests push expected bytes, a
// cycle-accurate UART monitor pops and checks every bit, tx_busy and tx_done.
module tb_ble_auth_tx;

    localparam int unsigned BD    = 16;
    localparam int unsigned FRAME = 10 * BD;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic go_cmd   = 1'b0;
    logic stop_cmd = 1'b0;
    logic TX;
    logic tx_busy;
    logic tx_done;

    ble_auth_tx #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go_cmd   (go_cmd),
        .stop_cmd (stop_cmd),
        .TX       (TX),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk    = 0;
    int         n_fail   = 0;
    int         n_frames = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         mon_en   = 1'b0;
    bit         mon_act  = 1'b0;
    int         mon_cnt  = 0;
    logic [9:0] mon_frm  = '1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, one check set per clock cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
            if (mon_en) begin
                chk("rst_tx",   int'(TX),      1);
                chk("rst_busy", int'(tx_busy), 0);
                chk("rst_done", int'(tx_done), 0);
            end
        end else if (mon_en) begin
            if (!mon_act && TX == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                n_frames++;
                start_q.push_back(cyc);
                chk("frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) mon_frm = {1'b1, exp_q.pop_front(), 1'b0};
                else                  mon_frm = '1;
            end
            if (mon_act) begin
                chk("tx_bit",     int'(TX),      int'(mon_frm[mon_cnt / BD]));
                chk("busy_frame", int'(tx_busy), 1);
                chk("done_frame", int'(tx_done), int'(mon_cnt == FRAME - 1));
                mon_cnt++;
                if (mon_cnt == FRAME) mon_act = 1'b0;
            end else begin
                chk("busy_idle", int'(tx_busy), 0);
                chk("done_idle", int'(tx_done), 0);
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic req(input bit g, input bit s, output int n);
        n        = cyc;
        go_cmd   = g;
        stop_cmd = s;
        @(posedge clk); #1;
        go_cmd   = 1'b0;
        stop_cmd = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((tx_busy || mon_act) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, int'(k < 3000), 1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, f0;

        // 1: reset values, then a quiet idle line
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx",   int'(TX),      1);
        chk("reset_busy", int'(tx_busy), 0);
        chk("reset_done", int'(tx_done), 0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_no_frame", n_frames, 0);

        // 2: single 'g' frame, start bit one cycle after the request
        f0 = n_frames;
        exp_q.push_back(8'h67);
        req(1'b1, 1'b0, n);
        wait_idle("t2_idle");
        chk("t2_frames",  n_frames - f0, 1);
        chk("t2_latency", start_q[start_q.size() - 1] - n, 1);

        // 3: go and stop together -> a single 's'
        f0 = n_frames;
        exp_q.push_back(8'h73);
        req(1'b1, 1'b1, n);
        wait_idle("t3_idle");
        repeat (200) @(posedge clk);
        #1;
        chk("t3_frames", n_frames - f0, 1);

        // 4: stop 50 cycles into a 'g' frame -> back-to-back 's'
        f0 = n_frames;
        exp_q.push_back(8'h67);
        exp_q.push_back(8'h73);
        req(1'b1, 1'b0, n);
        goto(n + 50);
        req(1'b0, 1'b1, n2);
        wait_idle("t4_idle");
        chk("t4_frames", n_frames - f0, 2);
        chk("t4_gap", start_q[start_q.size() - 1] - start_q[start_q.size() - 2], FRAME);

        // 5: pending 's' is not displaced by a later 'g'
        f0 = n_frames;
        exp_q.push_back(8'h67);
        exp_q.push_back(8'h73);
        req(1'b1, 1'b0, n);
        goto(n + 30);
        req(1'b0, 1'b1, n2);
        goto(n + 60);
        req(1'b1, 1'b0, n2);
        wait_idle("t5_idle");
        repeat (200) @(posedge clk);
        #1;
        chk("t5_frames", n_frames - f0, 2);

        // Request on the final stop cycle is still sent with no idle gap
        f0 = n_frames;
        exp_q.push_back(8'h67);
        exp_q.push_back(8'h67);
        req(1'b1, 1'b0, n);
        goto(n + 160);
        req(1'b1, 1'b0, n2);
        wait_idle("tc_idle");
        chk("tc_frames", n_frames - f0, 2);
        chk("tc_gap", start_q[start_q.size() - 1] - start_q[start_q.size() - 2], FRAME);

        // 6: reset at bit 4 (d3 = 0) with an 's' pending
        exp_q.push_back(8'h67);
        req(1'b1, 1'b0, n);
        goto(n + 20);
        req(1'b0, 1'b1, n2);
        goto(n + 1 + 4 * BD + 5);
        chk("t6_pre_tx", int'(TX), 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx",   int'(TX),      1);
        chk("t6_rst_busy", int'(tx_busy), 0);
        exp_q.delete();
        f0 = n_frames;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        chk("t6_no_frame", n_frames - f0, 0);
        chk("t6_idle_tx",  int'(TX), 1);

        chk("queue_empty", int'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
